// File: rtl/temp_frame_pkg.sv
// Shared byte-level definitions of the temperature frame, used by both the
// receive-side parser and the transmit-side formatter.
package temp_frame_pkg;

  localparam logic [7:0] B_HDR0  = 8'hCE;
  localparam logic [7:0] B_HDR1  = 8'hC2;
  localparam logic [7:0] B_HDR2  = 8'hB6;
  localparam logic [7:0] B_HDR3  = 8'hC8;
  localparam logic [7:0] B_COLON = 8'h3A;
  localparam logic [7:0] B_PLUS  = 8'h2B;
  localparam logic [7:0] B_MINUS = 8'h2D;
  localparam logic [7:0] B_POINT = 8'h2E;
  localparam logic [7:0] B_TRL0  = 8'hA1;
  localparam logic [7:0] B_TRL1  = 8'hE6;
  localparam logic [7:0] B_EOL   = 8'h0A;
  localparam logic [7:0] B_ZERO  = 8'h30;
  localparam logic [7:0] B_NINE  = 8'h39;

  localparam int FRAME_LEN = 16;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LITERAL = 2'd1;
  localparam logic [1:0] ERR_DIGIT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {CLS_LITERAL, CLS_SIGN, CLS_DIGIT} byte_class_e;

  function automatic byte_class_e byte_class(input logic [3:0] idx);
    case (idx)
      4'd5:                                     return CLS_SIGN;
      4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12:   return CLS_DIGIT;
      default:                                  return CLS_LITERAL;
    endcase
  endfunction

  // Only meaningful at literal positions; other indices return 0x00.
  function automatic logic [7:0] literal_at(input logic [3:0] idx);
    case (idx)
      4'd0:    return B_HDR0;
      4'd1:    return B_HDR1;
      4'd2:    return B_HDR2;
      4'd3:    return B_HDR3;
      4'd4:    return B_COLON;
      4'd8:    return B_POINT;
      4'd13:   return B_TRL0;
      4'd14:   return B_TRL1;
      4'd15:   return B_EOL;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= B_ZERO) && (b <= B_NINE);
  endfunction

endpackage

// File: rtl/temp_frame_parser.sv
// Parses 16-byte "+DD.DDDD" temperature frames from a UART byte stream into a
// sign and a 6-digit integer, with abort reporting, resync and inter-byte timeout.
module temp_frame_parser
  import temp_frame_pkg::*;
#(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter logic [27:0] BYTE_TIMEOUT = 28'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        sign,
  output logic [24:0] temp_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {IDLE, LITERAL, SIGN, DIGIT, DONE, ERR} state_e;

  // A zero timeout selects 100 ms at the given clock frequency.
  localparam logic [27:0] TIMEOUT_LIMIT =
    (BYTE_TIMEOUT == 28'd0) ? 28'(CLK_FREQ / 10) : BYTE_TIMEOUT;
  localparam logic [3:0]  LAST_IDX = 4'(FRAME_LEN - 1);

  state_e      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [24:0] acc, acc_n;
  logic [27:0] timer, timer_n;
  logic        sign_cap, sign_cap_n;
  logic        load, valid_n, err_n;
  logic [1:0]  code_n;

  byte_class_e cls;
  logic        byte_ok;
  logic        sof;
  logic [7:0]  digit_val;
  logic [24:0] acc_digit;

  function automatic state_e class_state(input byte_class_e c);
    case (c)
      CLS_SIGN:  return SIGN;
      CLS_DIGIT: return DIGIT;
      default:   return LITERAL;
    endcase
  endfunction

  assign sof       = rx_done && (rx_data == B_HDR0);
  assign digit_val = rx_data - B_ZERO;
  assign acc_digit = (acc << 3) + (acc << 1) + {17'd0, digit_val};

  always_comb begin
    cls     = byte_class(idx);
    byte_ok = 1'b0;
    case (cls)
      CLS_LITERAL: byte_ok = (rx_data == literal_at(idx));
      CLS_SIGN:    byte_ok = (rx_data == B_PLUS) || (rx_data == B_MINUS);
      default:     byte_ok = is_digit(rx_data);
    endcase
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first; a path that skips an
    // assignment would otherwise infer a latch.
    state_n    = state;
    idx_n      = idx;
    acc_n      = acc;
    timer_n    = timer;
    sign_cap_n = sign_cap;
    load       = 1'b0;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    code_n     = err_code;

    case (state)
      LITERAL, SIGN, DIGIT: begin
        if (timer >= TIMEOUT_LIMIT) begin
          // Expiry wins over a coincident byte, which is then judged as if idle.
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = IDLE;
          idx_n   = 4'd0;
          timer_n = 28'd0;
          if (sof) begin
            state_n = LITERAL;
            idx_n   = 4'd1;
            acc_n   = 25'd0;
          end
        end else if (rx_done) begin
          timer_n = 28'd0;
          if (byte_ok) begin
            if (cls == CLS_SIGN)  sign_cap_n = (rx_data == B_MINUS);
            if (cls == CLS_DIGIT) acc_n      = acc_digit;
            if (idx == LAST_IDX) begin
              state_n = DONE;
              idx_n   = 4'd0;
              load    = 1'b1;
              valid_n = 1'b1;
            end else begin
              idx_n   = idx + 4'd1;
              state_n = class_state(byte_class(idx + 4'd1));
            end
          end else begin
            err_n   = 1'b1;
            code_n  = (cls == CLS_DIGIT) ? ERR_DIGIT : ERR_LITERAL;
            state_n = ERR;
            idx_n   = 4'd0;
            if (sof) begin
              state_n = LITERAL;
              idx_n   = 4'd1;
              acc_n   = 25'd0;
            end
          end
        end else begin
          timer_n = timer + 28'd1;
        end
      end

      default: begin
        // IDLE, DONE and ERR all wait for a header byte; DONE/ERR last one cycle.
        state_n = IDLE;
        idx_n   = 4'd0;
        timer_n = 28'd0;
        if (sof) begin
          state_n = LITERAL;
          idx_n   = 4'd1;
          acc_n   = 25'd0;
        end
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 4'd0;
      acc         <= 25'd0;
      timer       <= 28'd0;
      sign_cap    <= 1'b0;
      sign        <= 1'b0;
      temp_data   <= 25'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      acc         <= acc_n;
      timer       <= timer_n;
      sign_cap    <= sign_cap_n;
      frame_valid <= valid_n;
      frame_err   <= err_n;
      err_code    <= code_n;
      if (load) begin
        sign      <= sign_cap;
        temp_data <= acc;
      end
    end
  end

endmodule

// File: tb/tb_temp_frame_parser.sv
// Self-checking bench for temp_frame_parser: directed scenarios plus randomized
// frames checked against a frame-level model of expected decode/abort outcomes.
module tb_temp_frame_parser;

  localparam logic [27:0] TO = 28'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        sign;
  logic [24:0] temp_data;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  err_code;

  temp_frame_parser #(.CLK_FREQ(50_000_000), .BYTE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .sign(sign), .temp_data(temp_data), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records cycle and payload of every frame_valid / frame_err.
  int v_cyc[$];
  int v_temp[$];
  int v_sign[$];
  int e_cyc[$];
  int e_code[$];

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      checks++;
      if (frame_valid && frame_err) begin
        failures++;
        $display("FAIL exclusive: frame_valid=1 and frame_err=1 at cycle %0d", cyc);
      end
    end
    if (frame_valid) begin
      v_cyc.push_back(cyc);
      v_temp.push_back(int'(temp_data));
      v_sign.push_back(int'(sign));
    end
    if (frame_err) begin
      e_cyc.push_back(cyc);
      e_code.push_back(int'(err_code));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] fb [16];
  int         sc [16];

  function automatic int pos_class(input int p);
    if (p == 5) return 1;
    if (p == 6 || p == 7 || (p >= 9 && p <= 12)) return 2;
    return 0;
  endfunction

  task automatic make_frame(input bit neg, input int value);
    int dpos [6];
    int v;
    dpos = '{12, 11, 10, 9, 7, 6};
    v = value;
    fb[0] = 8'hCE; fb[1] = 8'hC2; fb[2] = 8'hB6; fb[3] = 8'hC8; fb[4] = 8'h3A;
    fb[5] = neg ? 8'h2D : 8'h2B;
    fb[8] = 8'h2E;
    fb[13] = 8'hA1; fb[14] = 8'hE6; fb[15] = 8'h0A;
    for (int k = 0; k < 6; k++) begin
      fb[dpos[k]] = 8'h30 + 8'(v % 10);
      v = v / 10;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the strobe and gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap, output int scyc);
    rx_data = b;
    rx_done = 1'b1;
    scyc    = cyc;
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_range(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) send_byte(fb[i], gap, sc[i]);
  endtask

  task automatic clear_q();
    v_cyc.delete(); v_temp.delete(); v_sign.delete();
    e_cyc.delete(); e_code.delete();
  endtask

  task automatic settle();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (sign !== 1'b0)          begin failures++; $display("FAIL reset_sign: got %b want 0", sign); end
    if (temp_data !== 25'd0)    begin failures++; $display("FAIL reset_temp: got %0d want 0", temp_data); end
    if (frame_valid !== 1'b0)   begin failures++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    if (frame_err !== 1'b0)     begin failures++; $display("FAIL reset_err: got %b want 0", frame_err); end
    if (err_code !== 2'd0)      begin failures++; $display("FAIL reset_code: got %0d want 0", err_code); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    clear_q();
    make_frame(1'b0, 234567);
    send_range(0, 15, 1);
    settle();
    checks += 2;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL good_nvalid: got %0d want 1", v_cyc.size()); end
    if (e_cyc.size() != 0) begin failures++; $display("FAIL good_nerr: got %0d want 0", e_cyc.size()); end
    if (v_cyc.size() == 1) begin
      checks += 3;
      if (v_cyc[0] != sc[15] + 1) begin failures++; $display("FAIL good_latency: got cycle %0d want %0d", v_cyc[0], sc[15] + 1); end
      if (v_temp[0] != 234567)    begin failures++; $display("FAIL good_temp: got %0d want 234567", v_temp[0]); end
      if (v_sign[0] != 0)         begin failures++; $display("FAIL good_sign: got %0d want 0", v_sign[0]); end
    end
  endtask

  task automatic test_digit_error();
    clear_q();
    make_frame(1'b1, 50625);
    send_range(0, 15, 0);
    settle();
    checks += 3;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL neg_nvalid: got %0d want 1", v_cyc.size()); end
    if (temp_data !== 25'd50625) begin failures++; $display("FAIL neg_temp: got %0d want 50625", temp_data); end
    if (sign !== 1'b1) begin failures++; $display("FAIL neg_sign: got %b want 1", sign); end

    clear_q();
    make_frame(1'b0, 123456);
    fb[7] = 8'h41;
    send_range(0, 15, 0);
    settle();
    checks += 4;
    if (e_cyc.size() != 1) begin failures++; $display("FAIL digit_nerr: got %0d want 1", e_cyc.size()); end
    if (v_cyc.size() != 0) begin failures++; $display("FAIL digit_nvalid: got %0d want 0", v_cyc.size()); end
    if (temp_data !== 25'd50625) begin failures++; $display("FAIL digit_hold_temp: got %0d want 50625", temp_data); end
    if (sign !== 1'b1) begin failures++; $display("FAIL digit_hold_sign: got %b want 1", sign); end
    if (e_cyc.size() == 1) begin
      checks += 2;
      if (e_code[0] != 2)        begin failures++; $display("FAIL digit_code: got %0d want 2", e_code[0]); end
      if (e_cyc[0] != sc[7] + 1) begin failures++; $display("FAIL digit_latency: got cycle %0d want %0d", e_cyc[0], sc[7] + 1); end
    end
  endtask

  task automatic test_resync();
    int s0, s1;
    clear_q();
    send_byte(8'hCE, 1, s0);
    send_byte(8'hC2, 1, s1);
    make_frame(1'b0, 999999);
    send_range(0, 15, 1);
    settle();
    checks += 2;
    if (e_cyc.size() != 1) begin failures++; $display("FAIL resync_nerr: got %0d want 1", e_cyc.size()); end
    if (v_cyc.size() != 1) begin failures++; $display("FAIL resync_nvalid: got %0d want 1", v_cyc.size()); end
    if (e_cyc.size() == 1) begin
      checks += 2;
      if (e_code[0] != 1)        begin failures++; $display("FAIL resync_code: got %0d want 1", e_code[0]); end
      if (e_cyc[0] != sc[0] + 1) begin failures++; $display("FAIL resync_latency: got cycle %0d want %0d", e_cyc[0], sc[0] + 1); end
    end
    if (v_cyc.size() == 1) begin
      checks += 2;
      if (v_temp[0] != 999999)    begin failures++; $display("FAIL resync_temp: got %0d want 999999", v_temp[0]); end
      if (v_cyc[0] != sc[15] + 1) begin failures++; $display("FAIL resync_latency_valid: got cycle %0d want %0d", v_cyc[0], sc[15] + 1); end
    end
  endtask

  task automatic test_timeout();
    int delay;
    int val;
    clear_q();
    make_frame(1'b1, 777);
    send_range(0, 7, 0);
    for (int i = 0; i < int'(TO) + 20 && e_cyc.size() == 0; i++) @(posedge clk);
    #1;
    checks += 3;
    if (e_cyc.size() != 1) begin failures++; $display("FAIL timeout_nerr: got %0d want 1", e_cyc.size()); end
    if (temp_data !== 25'd999999) begin failures++; $display("FAIL timeout_hold_temp: got %0d want 999999", temp_data); end
    if (sign !== 1'b0) begin failures++; $display("FAIL timeout_hold_sign: got %b want 0", sign); end
    if (e_cyc.size() == 1) begin
      delay = e_cyc[0] - sc[7];
      checks += 2;
      if (e_code[0] != 3) begin failures++; $display("FAIL timeout_code: got %0d want 3", e_code[0]); end
      if (delay < int'(TO) || delay > int'(TO) + 3) begin
        failures++; $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", delay, TO, TO + 3);
      end
    end
    clear_q();
    val = int'($urandom_range(0, 999999));
    make_frame(1'b0, val);
    send_range(0, 15, 1);
    settle();
    checks += 3;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL post_timeout_nvalid: got %0d want 1", v_cyc.size()); end
    if (e_cyc.size() != 0) begin failures++; $display("FAIL post_timeout_nerr: got %0d want 0", e_cyc.size()); end
    if (temp_data !== 25'(val)) begin failures++; $display("FAIL post_timeout_temp: got %0d want %0d", temp_data, val); end
  endtask

  task automatic test_back_to_back();
    int va, vb, sa, sb, val;
    bit na, nb;
    clear_q();
    va = int'($urandom_range(0, 999999)); na = 1'($urandom_range(0, 1));
    vb = int'($urandom_range(0, 999999)); nb = 1'($urandom_range(0, 1));
    make_frame(na, va); send_range(0, 15, 0); sa = sc[15];
    make_frame(nb, vb); send_range(0, 15, 0); sb = sc[15];
    settle();
    checks += 2;
    if (v_cyc.size() != 2) begin failures++; $display("FAIL b2b_nvalid: got %0d want 2", v_cyc.size()); end
    if (e_cyc.size() != 0) begin failures++; $display("FAIL b2b_nerr: got %0d want 0", e_cyc.size()); end
    if (v_cyc.size() == 2) begin
      checks += 6;
      if (v_temp[0] != va)     begin failures++; $display("FAIL b2b_temp0: got %0d want %0d", v_temp[0], va); end
      if (v_sign[0] != int'(na)) begin failures++; $display("FAIL b2b_sign0: got %0d want %0d", v_sign[0], na); end
      if (v_cyc[0] != sa + 1)  begin failures++; $display("FAIL b2b_cyc0: got %0d want %0d", v_cyc[0], sa + 1); end
      if (v_temp[1] != vb)     begin failures++; $display("FAIL b2b_temp1: got %0d want %0d", v_temp[1], vb); end
      if (v_sign[1] != int'(nb)) begin failures++; $display("FAIL b2b_sign1: got %0d want %0d", v_sign[1], nb); end
      if (v_cyc[1] != sb + 1)  begin failures++; $display("FAIL b2b_cyc1: got %0d want %0d", v_cyc[1], sb + 1); end
    end

    clear_q();
    make_frame(1'b1, 424242);
    send_range(0, 10, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 5;
    if (sign !== 1'b0)        begin failures++; $display("FAIL midrst_sign: got %b want 0", sign); end
    if (temp_data !== 25'd0)  begin failures++; $display("FAIL midrst_temp: got %0d want 0", temp_data); end
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", frame_valid); end
    if (frame_err !== 1'b0)   begin failures++; $display("FAIL midrst_err: got %b want 0", frame_err); end
    if (err_code !== 2'd0)    begin failures++; $display("FAIL midrst_code: got %0d want 0", err_code); end
    send_range(11, 15, 0);
    settle();
    checks += 2;
    if (e_cyc.size() != 0) begin failures++; $display("FAIL midrst_nerr: got %0d want 0", e_cyc.size()); end
    if (v_cyc.size() != 0) begin failures++; $display("FAIL midrst_nvalid: got %0d want 0", v_cyc.size()); end

    clear_q();
    val = int'($urandom_range(0, 999999));
    make_frame(1'b1, val);
    send_range(0, 15, 0);
    settle();
    checks += 2;
    if (v_cyc.size() != 1) begin failures++; $display("FAIL post_rst_nvalid: got %0d want 1", v_cyc.size()); end
    if (temp_data !== 25'(val)) begin failures++; $display("FAIL post_rst_temp: got %0d want %0d", temp_data, val); end
  endtask

  task automatic test_random();
    int  exp_temp;
    bit  exp_sign;
    int  val, pos, cls, njunk, gap, dummy;
    bit  neg, corrupt, ok;
    logic [7:0] b;
    exp_temp = int'(temp_data);
    exp_sign = sign;
    for (int it = 0; it < 24; it++) begin
      clear_q();
      neg     = 1'($urandom_range(0, 1));
      val     = int'($urandom_range(0, 999999));
      gap     = int'($urandom_range(0, 2));
      corrupt = ($urandom_range(0, 2) == 0);
      pos     = int'($urandom_range(0, 15));
      cls     = pos_class(pos);
      make_frame(neg, val);
      if (corrupt) begin
        do begin
          b  = 8'($urandom_range(0, 255));
          ok = (b != 8'hCE) && (b != fb[pos]);
          if (cls == 1) ok = ok && (b != 8'h2B) && (b != 8'h2D);
          if (cls == 2) ok = ok && !(b >= 8'h30 && b <= 8'h39);
        end while (!ok);
        fb[pos] = b;
      end
      njunk = int'($urandom_range(0, 2));
      for (int j = 0; j < njunk; j++) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hCE);
        send_byte(b, gap, dummy);
      end
      send_range(0, 15, gap);
      settle();
      if (!corrupt) begin
        checks += 2;
        if (v_cyc.size() != 1 || e_cyc.size() != 0) begin
          failures++; $display("FAIL rnd%0d_good_events: got valid=%0d err=%0d want 1/0", it, v_cyc.size(), e_cyc.size());
        end
        exp_temp = val;
        exp_sign = neg;
        if (v_cyc.size() == 1 && v_cyc[0] != sc[15] + 1) begin
          failures++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, v_cyc[0], sc[15] + 1);
        end
      end else if (pos == 0) begin
        checks++;
        if (v_cyc.size() != 0 || e_cyc.size() != 0) begin
          failures++; $display("FAIL rnd%0d_silent: got valid=%0d err=%0d want 0/0", it, v_cyc.size(), e_cyc.size());
        end
      end else begin
        checks += 2;
        if (v_cyc.size() != 0 || e_cyc.size() != 1) begin
          failures++; $display("FAIL rnd%0d_abort_events: got valid=%0d err=%0d want 0/1", it, v_cyc.size(), e_cyc.size());
        end
        if (e_cyc.size() == 1 && (e_code[0] != (cls == 2 ? 2 : 1) || e_cyc[0] != sc[pos] + 1)) begin
          failures++; $display("FAIL rnd%0d_abort: pos=%0d got code=%0d cycle=%0d want code=%0d cycle=%0d",
                               it, pos, e_code[0], e_cyc[0], (cls == 2 ? 2 : 1), sc[pos] + 1);
        end
      end
      checks += 2;
      if (temp_data !== 25'(exp_temp)) begin failures++; $display("FAIL rnd%0d_temp: got %0d want %0d", it, temp_data, exp_temp); end
      if (sign !== exp_sign)           begin failures++; $display("FAIL rnd%0d_sign: got %b want %b", it, sign, exp_sign); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_digit_error();
    test_resync();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_frame_parser.md
TEMP_FRAME_PARSER -- requirements
Module: temp_frame_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BYTE_TIMEOUT, default 28'd5_000_000: maximum idle cycles between bytes inside one frame (100 ms).
REQ-003 SHALL have port clk  input  1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8: received byte from uart_rx, valid when rx_done=1.
REQ-006 SHALL have port rx_done  input  1: one-cycle byte strobe from uart_rx.
REQ-007 SHALL have port sign  output  1: sign of last good frame (1 = '-', 0 = '+').
REQ-008 SHALL have port temp_data  output  25: unsigned integer of the 6 digits of last good frame (e.g. 23.4567 -> 234567).
REQ-009 SHALL have port frame_valid  output  1: one-cycle pulse, new sign/temp_data loaded.
REQ-010 SHALL have port frame_err  output  1: one-cycle pulse, frame aborted.
REQ-011 SHALL have port err_code  output  2: cause of last abort (1 literal mismatch, 2 non-digit, 3 timeout); held until next abort.

Function
REQ-012 SHALL accept 16-byte frames: CE C2 B6 C8 3A, sign (2B/2D), D, D, 2E, D, D, D, D, A1 E6 0A, where D = 0x30..0x39.
REQ-013 SHALL use FSM states IDLE, LITERAL, SIGN, DIGIT, DONE, ERR; byte index counter 0..15 selects expected byte class.
REQ-014 SHALL leave IDLE only on rx_done with rx_data=0xCE; other bytes in IDLE are discarded silently (no frame_err).
REQ-015 SHALL, per digit, update accumulator acc <= acc*10 + (rx_data-0x30) in the rx_done cycle; acc cleared on frame start.
REQ-016 SHALL, on rx_done of index-15 byte 0x0A, load temp_data<=acc, sign<=captured sign, and pulse frame_valid exactly one cycle later.
REQ-017 SHALL, on literal/sign mismatch, pulse frame_err one cycle after the offending rx_done with err_code=1; on non-digit at a digit position, err_code=2.
REQ-018 SHALL resynchronise: an offending byte equal to 0xCE starts a new frame at index 1 in the same cycle as the abort.
REQ-019 SHALL count idle cycles since last rx_done while not in IDLE; count reaching BYTE_TIMEOUT pulses frame_err with err_code=3 and returns to IDLE.
REQ-020 SHALL never modify sign/temp_data on an aborted frame; outputs hold last good values.
REQ-021 SHALL treat rx_done in the same cycle as timeout expiry as arriving after the abort (timeout wins; byte re-evaluated as from IDLE).
REQ-022 SHALL handle back-to-back frames with zero gap: byte 0xCE immediately after 0x0A is accepted as new frame index 0.
REQ-023 SHALL keep frame_valid and frame_err mutually exclusive in every cycle.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, set state=IDLE, index=0, acc=0, timeout counter=0, sign=0, temp_data=0, frame_valid=0, frame_err=0, err_code=0.
REQ-025 SHALL abort a partial frame on reset mid-frame without pulsing frame_err; first byte after reset release is evaluated from IDLE.

Structure
REQ-026 SHALL place byte constants (CE C2 B6 C8 3A 2B 2D 2E A1 E6 0A), FRAME_LEN=16 and err_code values in shared package temp_frame_pkg, also used by the transmit-side formatter.
REQ-027 SHALL be a single module with no sub-module; uart_rx is instantiated by the parent and feeds rx_data/rx_done.
REQ-028 SHALL implement acc*10 as (acc<<3)+(acc<<1) in 25 bits; max 999999 cannot overflow.

Verification
REQ-029 SHALL cover: frame for "+23.4567" -> frame_valid one cycle after 0x0A strobe, temp_data=234567, sign=0, no frame_err.
REQ-030 SHALL cover: frame for "-05.0625" -> temp_data=50625, sign=1; then frame with byte 7 = 0x41 -> frame_err, err_code=2, temp_data stays 50625.
REQ-031 SHALL cover: CE C2 CE C2 B6 ... good frame "+99.9999" -> one frame_err (err_code=1), then frame_valid with temp_data=999999.
REQ-032 SHALL cover: 8 bytes of a frame then BYTE_TIMEOUT (reduced to 100 in sim) idle cycles -> frame_err, err_code=3, state IDLE; next full frame decodes.
REQ-033 SHALL cover: two frames back-to-back, zero gap -> two frame_valid pulses with correct values; rst=1 after byte 10 of a third frame -> all outputs zero, no frame_err.
